// File: rtl/rs_inorder_buf_pkg.sv
// Shared constants and helpers for the in-order reservation-station buffer.
//   ENT_NUM / ENT_SEL : entry count and its index width
//   DATA_LEN          : operand width
//   RRF_SEL           : rename tag width (tag lives in the low bits of a source)
//   PAY_LEN           : opaque payload width
//   DP_NUM_WIDTH      : width of the per-cycle dispatch count
//   PAY_*_LSB/_LEN    : field layout inside the opaque payload
package rs_inorder_buf_pkg;

  localparam int ENT_NUM      = 4;
  localparam int ENT_SEL      = 2;
  localparam int DATA_LEN     = 32;
  localparam int RRF_SEL      = 6;
  localparam int PAY_LEN      = 64;
  localparam int DP_NUM_WIDTH = 2;

  // Payload field layout; this block never decodes the payload, the
  // execution unit does.
  localparam int PAY_DST_LSB  = 0;
  localparam int PAY_DST_LEN  = RRF_SEL;
  localparam int PAY_IMM_LSB  = 8;
  localparam int PAY_IMM_LEN  = 32;
  localparam int PAY_OP_LSB   = 40;
  localparam int PAY_OP_LEN   = 8;
  localparam int PAY_CTL_LSB  = 48;
  localparam int PAY_CTL_LEN  = 16;

  // A CDB port hits a waiting source when it is valid and carries its tag.
  function automatic logic tag_hit(
    input logic               cdb_vld,
    input logic [RRF_SEL-1:0] cdb_tag,
    input logic [RRF_SEL-1:0] src_tag
  );
    return cdb_vld && (cdb_tag == src_tag);
  endfunction

endpackage

// File: rtl/rs_inorder_buf_if.sv
// Dispatch / CDB / issue bundle of the in-order reservation-station buffer.
//   master : driven by dispatch, the CDB and alloc_issue_order; sees the
//            occupancy vectors and the execution-unit read port
//   slave  : the buffer itself
interface rs_inorder_buf_if #(
  parameter int ENT_NUM      = rs_inorder_buf_pkg::ENT_NUM,
  parameter int ENT_SEL      = rs_inorder_buf_pkg::ENT_SEL,
  parameter int DATA_LEN     = rs_inorder_buf_pkg::DATA_LEN,
  parameter int RRF_SEL      = rs_inorder_buf_pkg::RRF_SEL,
  parameter int PAY_LEN      = rs_inorder_buf_pkg::PAY_LEN,
  parameter int DP_NUM_WIDTH = rs_inorder_buf_pkg::DP_NUM_WIDTH
) ();

  // dispatch
  logic                    i_flush;
  logic                    i_stall;
  logic [DP_NUM_WIDTH-1:0] i_req_num;
  logic [ENT_SEL-1:0]      i_alloc_sel_1;
  logic [ENT_SEL-1:0]      i_alloc_sel_2;
  logic [PAY_LEN-1:0]      i_pay_1;
  logic [PAY_LEN-1:0]      i_pay_2;
  logic [DATA_LEN-1:0]     i_srca_1;
  logic [DATA_LEN-1:0]     i_srcb_1;
  logic [DATA_LEN-1:0]     i_srca_2;
  logic [DATA_LEN-1:0]     i_srcb_2;
  logic                    i_rdya_1;
  logic                    i_rdyb_1;
  logic                    i_rdya_2;
  logic                    i_rdyb_2;

  // CDB broadcast
  logic                    i_cdb_vld_1;
  logic [RRF_SEL-1:0]      i_cdb_tag_1;
  logic [DATA_LEN-1:0]     i_cdb_data_1;
  logic                    i_cdb_vld_2;
  logic [RRF_SEL-1:0]      i_cdb_tag_2;
  logic [DATA_LEN-1:0]     i_cdb_data_2;

  // occupancy / issue
  logic [ENT_NUM-1:0]      o_busy_vec;
  logic [ENT_NUM-1:0]      o_vld_vec;
  logic [ENT_SEL-1:0]      i_issue_sel;
  logic                    i_issue_sel_vld;
  logic                    i_exe_rdy;
  logic                    o_issue_req;
  logic                    o_ex_vld;
  logic [PAY_LEN-1:0]      o_ex_pay;
  logic [DATA_LEN-1:0]     o_ex_srca;
  logic [DATA_LEN-1:0]     o_ex_srcb;

  modport master (
    output i_flush, i_stall, i_req_num, i_alloc_sel_1, i_alloc_sel_2,
           i_pay_1, i_pay_2, i_srca_1, i_srcb_1, i_srca_2, i_srcb_2,
           i_rdya_1, i_rdyb_1, i_rdya_2, i_rdyb_2,
           i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
           i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2,
           i_issue_sel, i_issue_sel_vld, i_exe_rdy,
    input  o_busy_vec, o_vld_vec, o_issue_req, o_ex_vld,
           o_ex_pay, o_ex_srca, o_ex_srcb
  );

  modport slave (
    input  i_flush, i_stall, i_req_num, i_alloc_sel_1, i_alloc_sel_2,
           i_pay_1, i_pay_2, i_srca_1, i_srcb_1, i_srca_2, i_srcb_2,
           i_rdya_1, i_rdyb_1, i_rdya_2, i_rdyb_2,
           i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
           i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2,
           i_issue_sel, i_issue_sel_vld, i_exe_rdy,
    output o_busy_vec, o_vld_vec, o_issue_req, o_ex_vld,
           o_ex_pay, o_ex_srca, o_ex_srcb
  );

endinterface

// File: rtl/rs_inorder_buf_src_wakeup.sv
// One source operand of one reservation-station entry.
// Holds a ready flag and a value; while not ready the value's low RRF_SEL
// bits are the rename tag being waited on. Captures data from the CDB both
// at dispatch (same-cycle bypass) and while the entry sits busy.
//   clk, rst_n      : clock, synchronous active-low reset
//   i_flush         : clears the ready flag
//   i_busy          : owning entry is occupied (enables wakeup)
//   i_we            : dispatch write into the owning entry
//   i_src, i_rdy    : dispatch value/tag and its ready flag
//   i_cdb_*_1/_2    : the two CDB broadcast ports, port 1 has priority
//   o_rdy, o_val    : stored ready flag and value/tag
module rs_src_wakeup #(
  parameter int DATA_LEN = rs_inorder_buf_pkg::DATA_LEN,
  parameter int RRF_SEL  = rs_inorder_buf_pkg::RRF_SEL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  input  logic                i_busy,
  input  logic                i_we,
  input  logic [DATA_LEN-1:0] i_src,
  input  logic                i_rdy,
  input  logic                i_cdb_vld_1,
  input  logic [RRF_SEL-1:0]  i_cdb_tag_1,
  input  logic [DATA_LEN-1:0] i_cdb_data_1,
  input  logic                i_cdb_vld_2,
  input  logic [RRF_SEL-1:0]  i_cdb_tag_2,
  input  logic [DATA_LEN-1:0] i_cdb_data_2,
  output logic                o_rdy,
  output logic [DATA_LEN-1:0] o_val
);
  import rs_inorder_buf_pkg::*;

  logic                rdy_q;
  logic [DATA_LEN-1:0] val_q;
  logic                rdy_d;
  logic [DATA_LEN-1:0] val_d;
  logic                val_ld;

  logic dp_hit_1, dp_hit_2, wk_hit_1, wk_hit_2;

  // Dispatch compares against the incoming tag, wakeup against the stored one.
  assign dp_hit_1 = tag_hit(i_cdb_vld_1, i_cdb_tag_1, i_src[RRF_SEL-1:0]);
  assign dp_hit_2 = tag_hit(i_cdb_vld_2, i_cdb_tag_2, i_src[RRF_SEL-1:0]);
  assign wk_hit_1 = tag_hit(i_cdb_vld_1, i_cdb_tag_1, val_q[RRF_SEL-1:0]);
  assign wk_hit_2 = tag_hit(i_cdb_vld_2, i_cdb_tag_2, val_q[RRF_SEL-1:0]);

  always_comb begin
    rdy_d  = rdy_q;
    val_d  = val_q;
    val_ld = 1'b0;
    if (i_flush) begin
      rdy_d = 1'b0;
    end else if (i_we) begin
      val_ld = 1'b1;
      if (i_rdy) begin
        rdy_d = 1'b1;
        val_d = i_src;
      end else if (dp_hit_1) begin
        rdy_d = 1'b1;
        val_d = i_cdb_data_1;
      end else if (dp_hit_2) begin
        rdy_d = 1'b1;
        val_d = i_cdb_data_2;
      end else begin
        rdy_d = 1'b0;
        val_d = i_src;
      end
    end else if (i_busy && !rdy_q) begin
      if (wk_hit_1) begin
        rdy_d  = 1'b1;
        val_d  = i_cdb_data_1;
        val_ld = 1'b1;
      end else if (wk_hit_2) begin
        rdy_d  = 1'b1;
        val_d  = i_cdb_data_2;
        val_ld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  // Value is don't-care after reset/flush, so it carries no reset.
  always_ff @(posedge clk) begin
    if (val_ld) begin
      val_q <= val_d;
    end
  end

  assign o_rdy = rdy_q;
  assign o_val = val_q;

endmodule

// File: rtl/rs_inorder_buf.sv
// In-order reservation-station entry storage for one execution pipe.
// Entries are written at the slots chosen by alloc_issue_order, snoop both
// CDB ports for missing operands, and the head entry (i_issue_sel) is read
// combinationally for the execution unit.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rs_inorder_buf_if.slave -- dispatch, CDB, occupancy
//                vectors (o_busy_vec, o_vld_vec) and the issue port
module rs_inorder_buf #(
  parameter int ENT_NUM  = rs_inorder_buf_pkg::ENT_NUM,
  parameter int ENT_SEL  = rs_inorder_buf_pkg::ENT_SEL,
  parameter int DATA_LEN = rs_inorder_buf_pkg::DATA_LEN,
  parameter int RRF_SEL  = rs_inorder_buf_pkg::RRF_SEL,
  parameter int PAY_LEN  = rs_inorder_buf_pkg::PAY_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  rs_inorder_buf_if.slave bus
);
  import rs_inorder_buf_pkg::*;

  logic [ENT_NUM-1:0]  busy;
  logic [ENT_NUM-1:0]  rdya;
  logic [ENT_NUM-1:0]  rdyb;
  logic [DATA_LEN-1:0] vala [ENT_NUM];
  logic [DATA_LEN-1:0] valb [ENT_NUM];
  logic [PAY_LEN-1:0]  pay  [ENT_NUM];

  logic                we_1;
  logic                we_2;
  logic [ENT_NUM-1:0]  sel_1;
  logic [ENT_NUM-1:0]  sel_2;
  logic [ENT_NUM-1:0]  ent_we;
  logic [PAY_LEN-1:0]  dp_pay  [ENT_NUM];
  logic [DATA_LEN-1:0] dp_srca [ENT_NUM];
  logic [DATA_LEN-1:0] dp_srcb [ENT_NUM];
  logic [ENT_NUM-1:0]  dp_rdya;
  logic [ENT_NUM-1:0]  dp_rdyb;

  logic                issue_req;
  logic                ex_vld;
  logic [ENT_NUM-1:0]  fire_clr;

  // Dispatch enables
  assign we_1 = !bus.i_stall && !bus.i_flush && (bus.i_req_num >= 1);
  assign we_2 = !bus.i_stall && !bus.i_flush && (bus.i_req_num == 2);

  // Per-entry dispatch mux; slot 2 wins if both slots ever name one entry.
  always_comb begin
    sel_1   = '0;
    sel_2   = '0;
    ent_we  = '0;
    dp_rdya = '0;
    dp_rdyb = '0;
    for (int unsigned e = 0; e < ENT_NUM; e++) begin
      sel_1[e]   = we_1 && (bus.i_alloc_sel_1 == ENT_SEL'(e));
      sel_2[e]   = we_2 && (bus.i_alloc_sel_2 == ENT_SEL'(e));
      ent_we[e]  = sel_1[e] || sel_2[e];
      dp_pay[e]  = sel_2[e] ? bus.i_pay_2  : bus.i_pay_1;
      dp_srca[e] = sel_2[e] ? bus.i_srca_2 : bus.i_srca_1;
      dp_srcb[e] = sel_2[e] ? bus.i_srcb_2 : bus.i_srcb_1;
      dp_rdya[e] = sel_2[e] ? bus.i_rdya_2 : bus.i_rdya_1;
      dp_rdyb[e] = sel_2[e] ? bus.i_rdyb_2 : bus.i_rdyb_1;
    end
  end

  // Issue handshake
  assign issue_req = bus.i_exe_rdy && !bus.i_flush;
  assign ex_vld    = issue_req && bus.i_issue_sel_vld;
  assign fire_clr  = ex_vld ? (ENT_NUM'(1) << bus.i_issue_sel) : '0;

  // Occupancy: a fired entry clears, a newly written one sets. The two never
  // target the same entry because a freed slot is only reallocated later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (bus.i_flush) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~fire_clr) | ent_we;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < ENT_NUM; e++) begin
      if (ent_we[e]) begin
        pay[e] <= dp_pay[e];
      end
    end
  end

  for (genvar e = 0; e < ENT_NUM; e++) begin : g_ent
    rs_src_wakeup #(
      .DATA_LEN (DATA_LEN),
      .RRF_SEL  (RRF_SEL)
    ) u_srca (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (bus.i_flush),
      .i_busy       (busy[e]),
      .i_we         (ent_we[e]),
      .i_src        (dp_srca[e]),
      .i_rdy        (dp_rdya[e]),
      .i_cdb_vld_1  (bus.i_cdb_vld_1),
      .i_cdb_tag_1  (bus.i_cdb_tag_1),
      .i_cdb_data_1 (bus.i_cdb_data_1),
      .i_cdb_vld_2  (bus.i_cdb_vld_2),
      .i_cdb_tag_2  (bus.i_cdb_tag_2),
      .i_cdb_data_2 (bus.i_cdb_data_2),
      .o_rdy        (rdya[e]),
      .o_val        (vala[e])
    );

    rs_src_wakeup #(
      .DATA_LEN (DATA_LEN),
      .RRF_SEL  (RRF_SEL)
    ) u_srcb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (bus.i_flush),
      .i_busy       (busy[e]),
      .i_we         (ent_we[e]),
      .i_src        (dp_srcb[e]),
      .i_rdy        (dp_rdyb[e]),
      .i_cdb_vld_1  (bus.i_cdb_vld_1),
      .i_cdb_tag_1  (bus.i_cdb_tag_1),
      .i_cdb_data_1 (bus.i_cdb_data_1),
      .i_cdb_vld_2  (bus.i_cdb_vld_2),
      .i_cdb_tag_2  (bus.i_cdb_tag_2),
      .i_cdb_data_2 (bus.i_cdb_data_2),
      .o_rdy        (rdyb[e]),
      .o_val        (valb[e])
    );
  end

  // Outputs
  assign bus.o_busy_vec  = busy;
  assign bus.o_vld_vec   = busy & rdya & rdyb;
  assign bus.o_issue_req = issue_req;
  assign bus.o_ex_vld    = ex_vld;
  assign bus.o_ex_pay    = pay[bus.i_issue_sel];
  assign bus.o_ex_srca   = vala[bus.i_issue_sel];
  assign bus.o_ex_srcb   = valb[bus.i_issue_sel];

endmodule

// File: tb/tb_rs_inorder_buf.sv
module tb_rs_inorder_buf;
  import rs_inorder_buf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_inorder_buf_if bus ();

  rs_inorder_buf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // ---------------- reference model ----------------
  // Entries as a circular queue: tail is where dispatch allocates, head is
  // the oldest entry; this stands in for alloc_issue_order.
  logic [3:0]  m_busy, m_rdya, m_rdyb;
  logic [31:0] m_vala [4];
  logic [31:0] m_valb [4];
  logic [63:0] m_pay  [4];
  logic [1:0]  m_head, m_tail;

  assign bus.i_issue_sel     = m_head;
  assign bus.i_alloc_sel_1   = m_tail;
  assign bus.i_alloc_sel_2   = m_tail + 2'd1;
  assign bus.i_issue_sel_vld = m_busy[m_head] & m_rdya[m_head] & m_rdyb[m_head];

  // A waiting operand takes CDB data on a tag match, port 1 first.
  function automatic void resolve(input logic r, input logic [31:0] v,
                                  output logic ro, output logic [31:0] vo);
    ro = r;
    vo = v;
    if (!r) begin
      if (bus.i_cdb_vld_1 && bus.i_cdb_tag_1 == v[5:0]) begin
        ro = 1'b1; vo = bus.i_cdb_data_1;
      end else if (bus.i_cdb_vld_2 && bus.i_cdb_tag_2 == v[5:0]) begin
        ro = 1'b1; vo = bus.i_cdb_data_2;
      end
    end
  endfunction

  logic [3:0]  nb, nra, nrb;
  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [63:0] pv [4];
  logic [1:0]  nh, nt, idx;

  always @(posedge clk) begin
    if (!rst_n || bus.i_flush) begin
      m_busy <= '0; m_rdya <= '0; m_rdyb <= '0;
      m_head <= '0; m_tail <= '0;
    end else begin
      nb = m_busy; nra = m_rdya; nrb = m_rdyb;
      va = m_vala; vb = m_valb; pv = m_pay;
      nh = m_head; nt = m_tail;
      for (int e = 0; e < 4; e++) begin
        if (m_busy[e]) begin
          resolve(m_rdya[e], m_vala[e], nra[e], va[e]);
          resolve(m_rdyb[e], m_valb[e], nrb[e], vb[e]);
        end
      end
      if (bus.i_exe_rdy && (m_busy[m_head] & m_rdya[m_head] & m_rdyb[m_head])) begin
        nb[m_head] = 1'b0;
        nh = m_head + 2'd1;
      end
      if (!bus.i_stall && bus.i_req_num >= 1) begin
        idx = m_tail;
        assert (!m_busy[idx]) else $error("FAIL protocol: dispatch into busy entry %0d", idx);
        nb[idx] = 1'b1;
        pv[idx] = bus.i_pay_1;
        resolve(bus.i_rdya_1, bus.i_srca_1, nra[idx], va[idx]);
        resolve(bus.i_rdyb_1, bus.i_srcb_1, nrb[idx], vb[idx]);
        nt = m_tail + 2'd1;
      end
      if (!bus.i_stall && bus.i_req_num == 2) begin
        idx = m_tail + 2'd1;
        assert (!m_busy[idx]) else $error("FAIL protocol: dispatch into busy entry %0d", idx);
        nb[idx] = 1'b1;
        pv[idx] = bus.i_pay_2;
        resolve(bus.i_rdya_2, bus.i_srca_2, nra[idx], va[idx]);
        resolve(bus.i_rdyb_2, bus.i_srcb_2, nrb[idx], vb[idx]);
        nt = m_tail + 2'd2;
      end
      m_busy <= nb; m_rdya <= nra; m_rdyb <= nrb;
      m_vala <= va; m_valb <= vb; m_pay <= pv;
      m_head <= nh; m_tail <= nt;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  logic [3:0] exp_vld;
  logic       exp_req, exp_fire;

  always @(negedge clk) begin
    if (started) begin
      exp_vld  = m_busy & m_rdya & m_rdyb;
      exp_req  = bus.i_exe_rdy && !bus.i_flush;
      exp_fire = exp_req && exp_vld[m_head];
      chk("model_busy_vec", 64'(bus.o_busy_vec), 64'(m_busy));
      chk("model_vld_vec", 64'(bus.o_vld_vec), 64'(exp_vld));
      chk("model_issue_req", 64'(bus.o_issue_req), 64'(exp_req));
      chk("model_ex_vld", 64'(bus.o_ex_vld), 64'(exp_fire));
      if (exp_fire) begin
        chk("model_ex_pay", bus.o_ex_pay, m_pay[m_head]);
        chk("model_ex_srca", 64'(bus.o_ex_srca), 64'(m_vala[m_head]));
        chk("model_ex_srcb", 64'(bus.o_ex_srcb), 64'(m_valb[m_head]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.i_flush = 1'b0; bus.i_stall = 1'b0; bus.i_req_num = '0;
    bus.i_pay_1 = '0; bus.i_pay_2 = '0;
    bus.i_srca_1 = '0; bus.i_srcb_1 = '0; bus.i_srca_2 = '0; bus.i_srcb_2 = '0;
    bus.i_rdya_1 = 1'b0; bus.i_rdyb_1 = 1'b0; bus.i_rdya_2 = 1'b0; bus.i_rdyb_2 = 1'b0;
    bus.i_cdb_vld_1 = 1'b0; bus.i_cdb_tag_1 = '0; bus.i_cdb_data_1 = '0;
    bus.i_cdb_vld_2 = 1'b0; bus.i_cdb_tag_2 = '0; bus.i_cdb_data_2 = '0;
  endtask

  // Advance one edge, return inputs to idle, let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic disp1(input logic [63:0] p, input logic [31:0] a, input logic ra,
                       input logic [31:0] b, input logic rb);
    bus.i_req_num = 2'd1;
    bus.i_pay_1 = p; bus.i_srca_1 = a; bus.i_rdya_1 = ra; bus.i_srcb_1 = b; bus.i_rdyb_1 = rb;
  endtask

  task automatic disp2(input logic [63:0] p, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_num = 2'd2;
    bus.i_pay_2 = p; bus.i_srca_2 = a; bus.i_rdya_2 = 1'b1; bus.i_srcb_2 = b; bus.i_rdyb_2 = 1'b1;
  endtask

  initial begin
    idle();
    bus.i_exe_rdy = 1'b1;
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_busy", 64'(bus.o_busy_vec), 64'h0);
    chk("reset_vld", 64'(bus.o_vld_vec), 64'h0);
    chk("reset_ex_vld", 64'(bus.o_ex_vld), 64'h0);
    chk("reset_issue_req", 64'(bus.o_issue_req), 64'h1);

    // two ready instructions into entries 0 and 1
    disp1(64'hA1, 32'h11, 1'b1, 32'h12, 1'b1);
    disp2(64'hB2, 32'h21, 32'h22);
    tick();
    chk("pair_vld_vec", 64'(bus.o_vld_vec), 64'h3);
    chk("pair_fire0", 64'(bus.o_ex_vld), 64'h1);
    chk("pair_pay0", bus.o_ex_pay, 64'hA1);
    chk("pair_srca0", 64'(bus.o_ex_srca), 64'h11);
    tick();
    chk("pair_busy_after0", 64'(bus.o_busy_vec), 64'h2);
    chk("pair_fire1", 64'(bus.o_ex_vld), 64'h1);
    chk("pair_pay1", bus.o_ex_pay, 64'hB2);
    chk("pair_srcb1", 64'(bus.o_ex_srcb), 64'h22);
    tick();
    chk("pair_drained", 64'(bus.o_busy_vec), 64'h0);

    // srca waits on tag 0x05; CDB port 2 delivers three cycles later (entry 2)
    disp1(64'hC3, 32'h05, 1'b0, 32'h33, 1'b1);
    tick();
    chk("wake_busy", 64'(bus.o_busy_vec), 64'h4);
    chk("wake_not_vld", 64'(bus.o_vld_vec), 64'h0);
    tick();
    tick();
    bus.i_cdb_vld_2 = 1'b1; bus.i_cdb_tag_2 = 6'h05; bus.i_cdb_data_2 = 32'hDEADBEEF;
    #1;
    chk("wake_no_same_cycle", 64'(bus.o_ex_vld), 64'h0);
    tick();
    chk("wake_vld", 64'(bus.o_vld_vec), 64'h4);
    chk("wake_fire", 64'(bus.o_ex_vld), 64'h1);
    chk("wake_srca", 64'(bus.o_ex_srca), 64'hDEADBEEF);
    tick();

    // srcb tag 0x07 bypassed from CDB port 1 in the dispatch cycle (entry 3)
    disp1(64'hD4, 32'h44, 1'b1, 32'h07, 1'b0);
    bus.i_cdb_vld_1 = 1'b1; bus.i_cdb_tag_1 = 6'h07; bus.i_cdb_data_1 = 32'h77777777;
    tick();
    chk("bypass_vld", 64'(bus.o_vld_vec), 64'h8);
    chk("bypass_srcb", 64'(bus.o_ex_srcb), 64'h77777777);
    tick();
    chk("bypass_drained", 64'(bus.o_busy_vec), 64'h0);

    // both ports hit one tag: port 1 data wins (entry 0, held with exe_rdy=0)
    bus.i_exe_rdy = 1'b0;
    disp1(64'hE5, 32'h09, 1'b0, 32'h55, 1'b1);
    tick();
    bus.i_cdb_vld_1 = 1'b1; bus.i_cdb_tag_1 = 6'h09; bus.i_cdb_data_1 = 32'h11111111;
    bus.i_cdb_vld_2 = 1'b1; bus.i_cdb_tag_2 = 6'h09; bus.i_cdb_data_2 = 32'h22222222;
    tick();
    chk("dual_vld", 64'(bus.o_vld_vec), 64'h1);
    chk("dual_srca", 64'(bus.o_ex_srca), 64'h11111111);
    chk("dual_no_fire", 64'(bus.o_ex_vld), 64'h0);

    // stall blocks writes
    bus.i_stall = 1'b1;
    disp1(64'hBAD, 32'h1, 1'b1, 32'h2, 1'b1);
    tick();
    chk("stall_busy", 64'(bus.o_busy_vec), 64'h1);

    // fill the rest, then flush
    disp1(64'hF1, 32'h1, 1'b1, 32'h2, 1'b1);
    disp2(64'hF2, 32'h3, 32'h4);
    tick();
    disp1(64'hF3, 32'h0A, 1'b0, 32'h5, 1'b1);
    tick();
    chk("fill_busy", 64'(bus.o_busy_vec), 64'hF);
    chk("fill_vld", 64'(bus.o_vld_vec), 64'h7);
    bus.i_exe_rdy = 1'b1;
    bus.i_flush = 1'b1;
    #1;
    chk("flush_no_fire", 64'(bus.o_ex_vld), 64'h0);
    chk("flush_issue_req", 64'(bus.o_issue_req), 64'h0);
    tick();
    chk("flush_busy", 64'(bus.o_busy_vec), 64'h0);
    chk("flush_vld", 64'(bus.o_vld_vec), 64'h0);

    // fire entry 0 while dispatching into entry 1
    disp1(64'h61, 32'h1, 1'b1, 32'h2, 1'b1);
    tick();
    chk("overlap_fire0", 64'(bus.o_ex_vld), 64'h1);
    disp1(64'h62, 32'h3, 1'b1, 32'h4, 1'b1);
    tick();
    chk("overlap_busy", 64'(bus.o_busy_vec), 64'h2);
    chk("overlap_pay1", bus.o_ex_pay, 64'h62);
    tick();
    chk("overlap_drained", 64'(bus.o_busy_vec), 64'h0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
